// File: rtl/ltc2308_ctrl.sv
`timescale 1ns/1ps
// Free-running round-robin scan controller for the LTC2308 8-channel 12-bit SPI ADC.
// Latency: the result of a conversion appears one frame after its channel was configured (pipelined ADC).
// Backpressure: none; result_valid is a one-cycle pulse that cannot be stalled, and result_ch/result_data hold until the next pulse.
//
// Ports:
//   clk, reset         : system clock, synchronous active-high reset
//   enable, ch_mask    : run continuous scan over the channels set in ch_mask
//   unipolar           : UNI bit placed in every config word
//   adc_convst/sck/sdi : ADC control pins; adc_sdo is the ADC serial data in
//   result_valid/ch/data : conversion result, tagged with the channel it belongs to
//   busy               : high while a frame is in progress
module ltc2308_ctrl #(
  parameter int CONVST_CYC = 2,
  parameter int CONV_CYC   = 80,
  parameter int SCK_LO_CYC = 1,
  parameter int SCK_HI_CYC = 1,
  parameter int FRAME_CYC  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic        unipolar,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [11:0] result_data,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CONVST, CONV_WAIT, SCK_LO, SCK_HI, GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;          // cycles spent in the current state
  logic [15:0] fcnt;         // cycles since the current frame's CONVST entry
  logic [3:0]  bit_idx;
  logic [2:0]  cur_ch;       // channel configured in this frame
  logic [2:0]  prev_ch;      // channel configured in the previous frame = owner of this frame's data
  logic [5:0]  cfg;          // config word, shifted left once per bit so cfg[5] is the bit on the wire
  logic [11:0] shift;
  logic        primed;
  logic [2:0]  next_ch;
  logic [2:0]  base;
  logic [2:0]  idx;
  logic        found;
  logic        cnt_last;
  logic        frame_go;
  logic        start_frame;

  assign frame_go    = enable && (ch_mask != 8'd0);
  assign start_frame = (state_nxt == CONVST) && (state != CONVST);

  // Round-robin pick: first set bit after the previous channel, wrapping.
  // Starting the scan from 7 when unprimed makes the first candidate channel 0,
  // which yields the lowest set bit for the first frame after IDLE.
  always_comb begin
    next_ch = 3'd0;
    found   = 1'b0;
    idx     = 3'd0;
    base    = primed ? cur_ch : 3'd7;
    for (int i = 1; i <= 8; i++) begin
      idx = base + 3'(i);
      if (!found && ch_mask[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_last = 1'b0;
    case (state)
      CONVST:    cnt_last = (cnt == 16'(CONVST_CYC - 1));
      CONV_WAIT: cnt_last = (cnt == 16'(CONV_CYC - 1));
      SCK_LO:    cnt_last = (cnt == 16'(SCK_LO_CYC - 1));
      SCK_HI:    cnt_last = (cnt == 16'(SCK_HI_CYC - 1));
      // GAP always lasts at least one cycle so the result pulse has a home
      GAP:       cnt_last = (fcnt >= 16'(FRAME_CYC - 1));
      default:   cnt_last = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (frame_go) state_nxt = CONVST;
      CONVST:    if (cnt_last) state_nxt = CONV_WAIT;
      CONV_WAIT: if (cnt_last) state_nxt = SCK_LO;
      SCK_LO:    if (cnt_last) state_nxt = SCK_HI;
      SCK_HI:    if (cnt_last) state_nxt = (bit_idx == 4'd11) ? GAP : SCK_LO;
      GAP:       if (cnt_last) state_nxt = frame_go ? CONVST : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    adc_convst = (state == CONVST);
    adc_sck    = (state == SCK_HI);
    adc_sdi    = ((state == SCK_LO) || (state == SCK_HI)) && cfg[5];
    busy       = (state != IDLE);
  end

  // Datapath: counters, channel pointer, config shifter, capture and result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= 16'd0;
      fcnt         <= 16'd0;
      bit_idx      <= 4'd0;
      cur_ch       <= 3'd0;
      prev_ch      <= 3'd0;
      cfg          <= 6'd0;
      shift        <= 12'd0;
      primed       <= 1'b0;
      result_valid <= 1'b0;
      result_ch    <= 3'd0;
      result_data  <= 12'd0;
    end else begin
      result_valid <= 1'b0;
      cnt          <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      if (state != IDLE) fcnt <= fcnt + 16'd1;

      if (start_frame) begin
        fcnt    <= 16'd0;
        bit_idx <= 4'd0;
        prev_ch <= cur_ch;
        cur_ch  <= next_ch;
        cfg     <= {1'b1, next_ch, unipolar, 1'b0};
      end

      if (state == SCK_HI && cnt_last) begin
        shift   <= {shift[10:0], adc_sdo};
        cfg     <= {cfg[4:0], 1'b0};
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd11) begin
          primed <= 1'b1;
          if (primed) begin
            result_valid <= 1'b1;
            result_ch    <= prev_ch;
            result_data  <= {shift[10:0], adc_sdo};
          end
        end
      end

      if (state == GAP && cnt_last && !frame_go) primed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ltc2308_ctrl.sv
`timescale 1ns/1ps
// Bench for ltc2308_ctrl: pin-level LTC2308 model, frame-timeline reference model, per-cycle compare.
// The frame period is raised to 110: the default 100 is shorter than the 107 cycles that the
// default convst, conversion and 12-bit SCK timings need.
module tb_ltc2308_ctrl;
  localparam int C = 2, W = 80, L = 1, H = 1, F = 110;
  localparam int T_RES   = C + W + 12 * (L + H);            // frame offset of the first GAP cycle
  localparam int T_FRAME = (F > T_RES) ? F : T_RES + 1;

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, unipolar = 1'b0, adc_sdo = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        adc_convst, adc_sck, adc_sdi, result_valid, busy;
  logic [2:0]  result_ch;
  logic [11:0] result_data;

  ltc2308_ctrl #(.CONVST_CYC(C), .CONV_CYC(W), .SCK_LO_CYC(L), .SCK_HI_CYC(H), .FRAME_CYC(F)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .unipolar(unipolar),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
    .result_valid(result_valid), .result_ch(result_ch), .result_data(result_data), .busy(busy));

  always #10 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ADC pin model ----------------
  logic [11:0] ch_val [8] = '{12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA, 12'h999, 12'h888};
  logic [5:0]  a_word = 6'd0;
  logic [2:0]  a_sel = 3'd0;
  logic [11:0] a_data = 12'd0;
  int          a_nbits = 0, a_k = 12, viol = 0;
  logic        a_cq = 1'b0, a_sq = 1'b0, a_dq = 1'b0;
  logic [5:0]  word_log [$];

  always @(posedge clk) begin
    #1;
    if (adc_convst === 1'b1 && !a_cq) begin
      a_data = ch_val[a_sel];   // converts the channel chosen by the last complete word
      a_k = 0;
      a_nbits = 0;
    end
    if (adc_sck === 1'b1 && !a_sq && a_nbits < 6) begin
      a_word = {a_word[4:0], adc_sdi};
      a_nbits++;
      if (a_nbits == 6) begin
        a_sel = a_word[4:2];
        word_log.push_back(a_word);
      end
    end
    if (adc_sck === 1'b1 && adc_sdi !== a_dq) viol++;
    if (adc_sck !== 1'b1 && a_sq) a_k++;
    adc_sdo = (a_k < 12) ? a_data[11 - a_k] : 1'b0;
    a_cq = (adc_convst === 1'b1);
    a_sq = (adc_sck === 1'b1);
    a_dq = adc_sdi;
  end

  // ---------------- Reference model (frame timeline) ----------------
  bit          m_act = 0, m_primed = 0, m_vld = 0, cmp_en = 0;
  int          m_t = 0, m_cur = 0, m_prev = 0;
  logic [5:0]  m_cfg = 6'd0;
  logic [2:0]  m_rch = 3'd0;
  logic [11:0] m_rdat = 12'd0;

  function automatic int pick(input logic [7:0] mask, input bit first, input int prev);
    if (first) begin
      for (int i = 0; i < 8; i++) if (mask[i]) return i;
    end else begin
      for (int i = 1; i <= 8; i++) if (mask[(prev + i) % 8]) return (prev + i) % 8;
    end
    return 0;
  endfunction

  task automatic m_start();
    m_act  = 1;
    m_t    = 0;
    m_prev = m_cur;
    m_cur  = pick(ch_mask, !m_primed, m_cur);
    m_cfg  = {1'b1, 3'(m_cur), unipolar, 1'b0};
  endtask

  always @(posedge clk) begin
    m_vld = 0;
    if (reset) begin
      m_act = 0; m_primed = 0; m_cur = 0; m_rch = 3'd0; m_rdat = 12'd0; cmp_en = 1;
    end else if (!m_act) begin
      if (enable && ch_mask != 8'd0) m_start();
    end else begin
      m_t++;
      if (m_t == T_RES) begin
        if (m_primed) begin
          m_vld = 1; m_rch = 3'(m_prev); m_rdat = ch_val[m_prev];
        end
        m_primed = 1;
      end
      if (m_t == T_FRAME) begin
        if (enable && ch_mask != 8'd0) m_start();
        else begin m_act = 0; m_primed = 0; end
      end
    end
  end

  // ---------------- Per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    int   off;
    logic e_sck, e_sdi;
    if (cmp_en) begin
      e_sck = 1'b0;
      e_sdi = 1'b0;
      if (m_act && m_t >= C + W && m_t < T_RES) begin
        off   = m_t - C - W;
        e_sck = (off % (L + H)) >= L;
        if (off / (L + H) < 6) e_sdi = m_cfg[5 - off / (L + H)];
      end
      check("busy", busy, m_act);
      check("adc_convst", adc_convst, m_act && m_t < C);
      check("adc_sck", adc_sck, e_sck);
      check("adc_sdi", adc_sdi, e_sdi);
      check("result_valid", result_valid, m_vld);
      check("result_ch", result_ch, m_rch);
      check("result_data", result_data, m_rdat);
    end
  end

  // ---------------- Monitors ----------------
  int          cyc = 0, convst_rises = 0, conv_hi = 0, last_conv_hi = 0;
  int          fall_cyc = 0, last_gap = 0, sck_cnt = 0, last_sck_cnt = 0;
  bit          first_sck_seen = 0, busy_seen = 0;
  logic        pc = 1'b0, ps = 1'b0;
  logic [2:0]  v_ch [$];
  logic [11:0] v_dat [$];

  always @(negedge clk) begin
    cyc++;
    if (result_valid === 1'b1) begin
      v_ch.push_back(result_ch);
      v_dat.push_back(result_data);
    end
    if (adc_convst === 1'b1) begin
      if (!pc) begin
        convst_rises++; last_sck_cnt = sck_cnt; sck_cnt = 0; conv_hi = 0;
      end
      conv_hi++;
    end else if (pc) begin
      last_conv_hi = conv_hi; fall_cyc = cyc; first_sck_seen = 0;
    end
    if (adc_sck === 1'b1 && !ps) begin
      sck_cnt++;
      if (!first_sck_seen) begin last_gap = cyc - fall_cyc; first_sck_seen = 1; end
    end
    if (busy === 1'b1) busy_seen = 1;
    pc = (adc_convst === 1'b1);
    ps = (adc_sck === 1'b1);
  end

  // ---------------- Stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic wait_convst(input int budget);
    int r0, k;
    r0 = convst_rises;
    k = 0;
    while (convst_rises == r0 && k < budget) begin cycles(1); k++; end
    check("wait_convst_rise", convst_rises != r0, 1);
  endtask

  task automatic check_res(input string name, input int i, input logic [2:0] ch, input logic [11:0] dat);
    check({name, "_present"}, v_ch.size() > i, 1);
    if (v_ch.size() > i) begin
      check({name, "_ch"}, v_ch[i], ch);
      check({name, "_data"}, v_dat[i], dat);
    end
  endtask

  logic [2:0]  exp_ch8 [9]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [11:0] exp_d8  [9]  = '{12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA, 12'h999, 12'h888, 12'hFFF};

  initial begin
    int n0, n1, w0, r0;
    // Reset state
    reset = 1'b1;
    cycles(3);
    check("rst_busy", busy, 0);
    check("rst_convst", adc_convst, 0);
    check("rst_sck", adc_sck, 0);
    check("rst_sdi", adc_sdi, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ch", result_ch, 0);
    check("rst_data", result_data, 0);
    reset = 1'b0;

    // Single channel: frame 1 unprimed, then one result per frame
    n0 = v_ch.size();
    ch_mask = 8'h01; enable = 1'b1;
    cycles(4 * T_FRAME);
    check("m01_count", v_ch.size() - n0, 3);
    check_res("m01_r0", n0, 3'd0, 12'hFFF);
    check_res("m01_r2", n0 + 2, 3'd0, 12'hFFF);

    // All channels, wrap back to 0
    do_reset();
    n0 = v_ch.size();
    ch_mask = 8'hFF;
    cycles(10 * T_FRAME);
    check("mff_count", v_ch.size() - n0, 9);
    for (int i = 0; i < 9; i++) check_res("mff", n0 + i, exp_ch8[i], exp_d8[i]);

    // Sparse mask, unipolar, config words and pin timing
    do_reset();
    n0 = v_ch.size();
    w0 = word_log.size();
    ch_mask = 8'h82; unipolar = 1'b1;
    cycles(4 * T_FRAME);
    check("m82_count", v_ch.size() - n0, 3);
    check_res("m82_r0", n0, 3'd1, 12'hEEE);
    check_res("m82_r1", n0 + 1, 3'd7, 12'h888);
    check_res("m82_r2", n0 + 2, 3'd1, 12'hEEE);
    check("m82_words", word_log.size() - w0 >= 3, 1);
    if (word_log.size() - w0 >= 3) begin
      check("m82_word0", word_log[w0], 6'b100110);
      check("m82_word1", word_log[w0 + 1], 6'b111110);
      check("m82_word2", word_log[w0 + 2], 6'b100110);
    end
    check("convst_high_cycles", last_conv_hi, C);
    // CONV_WAIT spans W cycles, then the first bit's low phase precedes the rise
    check("convst_fall_to_sck_rise", last_gap, W + L);
    check("sck_pulses_per_frame", last_sck_cnt, 12);
    check("sdi_stable_while_sck_high", viol, 0);
    unipolar = 1'b0;

    // Empty mask keeps the block idle; then a single channel
    do_reset();
    ch_mask = 8'h00;
    r0 = convst_rises;
    busy_seen = 0;
    cycles(200);
    check("m00_no_convst", convst_rises - r0, 0);
    check("m00_never_busy", busy_seen, 0);
    n0 = v_ch.size();
    ch_mask = 8'h10;
    cycles(2 * T_FRAME + 5);
    check("m10_count", v_ch.size() - n0, 1);
    check_res("m10_r0", n0, 3'd4, 12'hBBB);

    // Reset during bit 5 of a primed frame
    do_reset();
    ch_mask = 8'h01;
    cycles(2 * T_FRAME + 20);
    wait_convst(T_FRAME + 5);
    cycles(C + W + 5 * (L + H) - 1);
    n0 = v_ch.size();
    reset = 1'b1;
    cycles(1);
    check("midrst_sck", adc_sck, 0);
    check("midrst_convst", adc_convst, 0);
    check("midrst_busy", busy, 0);
    check("midrst_no_result", v_ch.size() - n0, 0);
    reset = 1'b0;
    cycles(T_FRAME + 20);
    check("midrst_unprimed", v_ch.size() - n0, 0);
    cycles(T_FRAME);
    check("midrst_next_result", v_ch.size() - n0, 1);

    // Enable dropped during CONV_WAIT of frame 3
    do_reset();
    n0 = v_ch.size();
    ch_mask = 8'hFF;
    wait_convst(T_FRAME + 5);
    wait_convst(T_FRAME + 5);
    wait_convst(T_FRAME + 5);
    cycles(20);
    enable = 1'b0;
    cycles(T_FRAME);
    check("endrop_count", v_ch.size() - n0, 2);
    check_res("endrop_r0", n0, 3'd0, 12'hFFF);
    check_res("endrop_r1", n0 + 1, 3'd1, 12'hEEE);
    check("endrop_idle", busy, 0);
    n1 = v_ch.size();
    enable = 1'b1;
    cycles(T_FRAME + 20);
    check("reen_unprimed", v_ch.size() - n1, 0);
    cycles(T_FRAME);
    check("reen_count", v_ch.size() - n1, 1);
    check_res("reen_r0", n1, 3'd0, 12'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
